ac97_cmd_arbiter: RTL and testbench
===================================

AC97_CMD_ARBITER -- requirements
Module: ac97_cmd_arbiter

Interface
REQ-001 SHALL have port: clock_27mhz  in  1  system clock; one clock; all state on rising edge.
REQ-002 SHALL have port: reset_b  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: ready  in  1  one-cycle pulse per AC97 frame, synchronous to clock_27mhz; marks a command-slot boundary.
REQ-004 SHALL have port: volume  in  5  headphone volume, 31 = loudest.
REQ-005 SHALL have port: source  in  3  record source select.
REQ-006 SHALL have ports: req  in  2  per-requester command request, level.
REQ-007 SHALL have ports: req0_cmd and req1_cmd  in  24  each {addr[7:0], data[15:0]}; bit 23 of addr = read.
REQ-008 SHALL have port: gnt  out  2  one-cycle pulse, one-hot, requester command accepted.
REQ-009 SHALL have ports: command_address  out  8, and command_data  out  16, holding the command for the current frame.
REQ-010 SHALL have port: command_valid  out  1  command slot valid.
REQ-011 SHALL have port: init_done  out  1  high once the init table has fully issued.

Function
REQ-012 SHALL be a three-state FSM: INIT, IDLE, ISSUE; all transitions occur only in a cycle with ready=1.
REQ-013 SHALL load a new command into command_address/command_data on the ready cycle and hold it unchanged until the next ready pulse (one command per frame).
REQ-014 SHALL in INIT issue an 8-entry table, one entry per ready, in order:
- 80_0000
- {04, 000, vol, 000, vol}
- 18_0808
- {1A, 00000, source, 00000, source}
- 1C_0F0F
- 0E_8048
- 0A_0000
- 20_8000
REQ-015 SHALL compute vol = 31 - volume (5-bit attenuation), sampled on the issuing ready cycle.
REQ-016 SHALL set init_done and enter IDLE on the ready pulse after table entry 7 is loaded; requests during INIT SHALL be held pending, not granted.
REQ-017 SHALL use this priority outside INIT: pending volume update > requesters; no winner -> filler command 80_0000, state IDLE.
REQ-018 SHALL keep vol_last. When volume != vol_last, a volume update is pending. The update issues command {04, 000, vol, 000, vol} and copies volume into vol_last on the same ready. A further change while pending issues the value current at issue time.
REQ-019 SHALL sample req on the ready cycle. For the winner: load reqN_cmd, pulse gnt[N] in that same cycle, and enter ISSUE. In ISSUE, the next ready returns to IDLE or issues the next winner directly.
REQ-020 SHALL require each requester to hold req and cmd stable until gnt. A req dropped before a ready cycle SHALL NOT be granted. A req still high on the ready cycle after its gnt SHALL count as a new request.
REQ-021 SHALL assert command_valid=1 from the first ready after reset onward, including for filler commands.
REQ-022 SHALL never assert more than one gnt bit, and SHALL assert gnt only on a ready cycle.

Reset
REQ-023 SHALL, on reset_b=0, immediately force these values:
- state=INIT, table index=0, init_done=0
- gnt=00, command_valid=0, command_address=00, command_data=0000
- vol_last=volume-independent 0, round-robin pointer=req0
REQ-024 SHALL abort any in-progress issue on reset mid-frame, issue no gnt, and restart the table at entry 0 on the first ready after release.

Configuration
REQ-025 SHALL honour macro AC97_ARB_ROUND_ROBIN_EN. Defined: round-robin between req0 and req1; the pointer moves past each grantee. Undefined: fixed priority, req0 over req1, no pointer register.

Verification
REQ-026 SHALL cover: reset release, volume=31, source=0, 8 ready pulses -> commands 80_0000, 04_0000, 18_0808, 1A_0000, 1C_0F0F, 0E_8048, 0A_0000, 20_8000 in order; init_done high after the 8th.
REQ-027 SHALL cover: after init, volume 31->20 -> next ready issues 04_0B0B (vol=11); following ready issues filler 80_0000.
REQ-028 SHALL cover: req=11 held with req0_cmd=18_0404, req1_cmd=1C_0000 over 4 ready pulses:
- with AC97_ARB_ROUND_ROBIN_EN: grants 0,1,0,1
- without: grants 0,0,0,0
REQ-029 SHALL cover: volume change and req0 on the same ready -> volume command first; gnt[0] on the following ready.
REQ-030 SHALL cover: reset_b low during ISSUE of a req1 command -> outputs reset immediately; no gnt; table restarts at 80_0000.

Source files
------------

// File: rtl/ac97_cmd_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ac97_cmd_arbiter
// Purpose  : Issues one AC97 command per frame. It first plays an 8-entry
//            codec init table, then arbitrates between pending volume updates
//            and two external requesters. A filler command is issued when
//            there is nothing else to send.
// Options  : AC97_ARB_ROUND_ROBIN_EN - round-robin between req0 and req1
//            (default: fixed priority, req0 over req1)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module ac97_cmd_arbiter (
    input  logic        clock_27mhz,
    input  logic        reset_b,
    input  logic        ready,
    input  logic [4:0]  volume,
    input  logic [2:0]  source,
    input  logic [1:0]  req,
    input  logic [23:0] req0_cmd,
    input  logic [23:0] req1_cmd,
    output logic [1:0]  gnt,
    output logic [7:0]  command_address,
    output logic [15:0] command_data,
    output logic        command_valid,
    output logic        init_done
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam logic [23:0] FILLER_CMD = 24'h80_0000;

    state_t      state, state_next;
    logic [2:0]  tbl_idx, tbl_idx_next;
    logic [4:0]  vol_last, vol_last_next;
    logic        done_next;
    logic [23:0] cmd_next;
    logic [23:0] tbl_cmd;
    logic [23:0] vol_cmd;
    logic [4:0]  vol_att;
    logic        vol_pending;
    logic [1:0]  win;

    // Headphone attenuation: 31 = loudest maps to 0 dB attenuation.
    assign vol_att     = 5'd31 - volume;
    assign vol_cmd     = {8'h04, 3'b000, vol_att, 3'b000, vol_att};
    assign vol_pending = (volume != vol_last);

    // Codec init table; the volume and source entries track the live inputs.
    always_comb begin
        tbl_cmd = FILLER_CMD;
        case (tbl_idx)
            3'd0: tbl_cmd = 24'h80_0000;
            3'd1: tbl_cmd = vol_cmd;
            3'd2: tbl_cmd = 24'h18_0808;
            3'd3: tbl_cmd = {8'h1A, 5'b00000, source, 5'b00000, source};
            3'd4: tbl_cmd = 24'h1C_0F0F;
            3'd5: tbl_cmd = 24'h0E_8048;
            3'd6: tbl_cmd = 24'h0A_0000;
            3'd7: tbl_cmd = 24'h20_8000;
            default: tbl_cmd = FILLER_CMD;
        endcase
    end

`ifdef AC97_ARB_ROUND_ROBIN_EN
    // rr_ptr=1 means req1 is preferred when both requesters are active.
    logic rr_ptr, rr_ptr_next;

    // Round-robin winner selection (one-hot).
    always_comb begin
        win = 2'b00;
        if (req == 2'b11) begin
            win = rr_ptr ? 2'b10 : 2'b01;
        end else begin
            win = req;
        end
    end

    // Pointer register moves past each grantee.
    always_ff @(posedge clock_27mhz or negedge reset_b) begin
        if (!reset_b) begin
            rr_ptr <= 1'b0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end
`else
    // Fixed-priority winner selection: req0 beats req1.
    always_comb begin
        win = 2'b00;
        if (req[0]) begin
            win = 2'b01;
        end else if (req[1]) begin
            win = 2'b10;
        end
    end
`endif

    // Next-state, next-command and grant decode; all changes happen on ready.
    always_comb begin
        state_next    = state;
        tbl_idx_next  = tbl_idx;
        vol_last_next = vol_last;
        done_next     = init_done;
        cmd_next      = {command_address, command_data};
        gnt           = 2'b00;
`ifdef AC97_ARB_ROUND_ROBIN_EN
        rr_ptr_next   = rr_ptr;
`endif
        if (ready) begin
            case (state)
                ST_INIT: begin
                    cmd_next     = tbl_cmd;
                    tbl_idx_next = tbl_idx + 3'd1;
                    // The table's volume entry also brings vol_last up to date.
                    if (tbl_idx == 3'd1) begin
                        vol_last_next = volume;
                    end
                    if (tbl_idx == 3'd7) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    if (vol_pending) begin
                        cmd_next      = vol_cmd;
                        vol_last_next = volume;
                        state_next    = ST_ISSUE;
                    end else if (win != 2'b00) begin
                        gnt        = win;
                        cmd_next   = win[0] ? req0_cmd : req1_cmd;
                        state_next = ST_ISSUE;
`ifdef AC97_ARB_ROUND_ROBIN_EN
                        rr_ptr_next = win[0];
`endif
                    end else begin
                        cmd_next   = FILLER_CMD;
                        state_next = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // State and command registers with asynchronous active-low reset.
    always_ff @(posedge clock_27mhz or negedge reset_b) begin
        if (!reset_b) begin
            state           <= ST_INIT;
            tbl_idx         <= 3'd0;
            vol_last        <= 5'd0;
            init_done       <= 1'b0;
            command_valid   <= 1'b0;
            command_address <= 8'h00;
            command_data    <= 16'h0000;
        end else begin
            state           <= state_next;
            tbl_idx         <= tbl_idx_next;
            vol_last        <= vol_last_next;
            init_done       <= done_next;
            command_valid   <= command_valid | ready;
            command_address <= cmd_next[23:16];
            command_data    <= cmd_next[15:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ac97_cmd_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_ac97_cmd_arbiter
// Purpose  : Self-checking bench for ac97_cmd_arbiter: directed frames with
//            literal expectations plus randomized frames against a
//            frame-level behavioural model.
// Options  : AC97_ARB_ROUND_ROBIN_EN selects round-robin expectations
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ac97_cmd_arbiter;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        ready = 1'b0;
    logic [4:0]  volume = 5'd31;
    logic [2:0]  source = 3'd0;
    logic [1:0]  req = 2'b00;
    logic [23:0] req0_cmd = 24'h0;
    logic [23:0] req1_cmd = 24'h0;
    logic [1:0]  gnt;
    logic [7:0]  command_address;
    logic [15:0] command_data;
    logic        command_valid;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    ac97_cmd_arbiter dut (
        .clock_27mhz     (clk),
        .reset_b         (reset_b),
        .ready           (ready),
        .volume          (volume),
        .source          (source),
        .req             (req),
        .req0_cmd        (req0_cmd),
        .req1_cmd        (req1_cmd),
        .gnt             (gnt),
        .command_address (command_address),
        .command_data    (command_data),
        .command_valid   (command_valid),
        .init_done       (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int          m_frames;      // ready pulses seen since reset
    bit          m_done;
    bit          m_valid;
    logic [4:0]  m_vol_last;
    int          m_pref;        // preferred requester when both ask (round-robin)
    logic [23:0] m_cmd;

    function automatic void model_reset();
        m_frames   = 0;
        m_done     = 0;
        m_valid    = 0;
        m_vol_last = 5'd0;
        m_pref     = 0;
        m_cmd      = 24'h0;
    endfunction

    function automatic logic [23:0] vol_word(input logic [4:0] v);
        int a;
        a = 31 - int'(v);
        return (24'h04 << 16) | (24'(a) << 8) | 24'(a);
    endfunction

    function automatic logic [23:0] init_word(input int n);
        logic [23:0] t [8];
        t[0] = 24'h80_0000;
        t[1] = vol_word(volume);
        t[2] = 24'h18_0808;
        t[3] = (24'h1A << 16) | (24'(source) << 8) | 24'(source);
        t[4] = 24'h1C_0F0F;
        t[5] = 24'h0E_8048;
        t[6] = 24'h0A_0000;
        t[7] = 24'h20_8000;
        return t[n];
    endfunction

    // Which requester (0/1) wins, or -1 when nobody asks.
    function automatic int pick_winner();
        if (req[0] && req[1]) begin
`ifdef AC97_ARB_ROUND_ROBIN_EN
            return m_pref;
`else
            return 0;
`endif
        end
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    initial model_reset();

    // Compare outputs each cycle, then advance the model on ready frames.
    always @(negedge clk) begin
        logic [1:0] eg;
        int w;
        if (!reset_b) begin
            model_reset();
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_cmd", 32'({command_address, command_data}), 32'd0);
            chk("rst_valid", 32'(command_valid), 32'd0);
            chk("rst_init_done", 32'(init_done), 32'd0);
        end else begin
            chk("cmd", 32'({command_address, command_data}), 32'(m_cmd));
            chk("valid", 32'(command_valid), 32'(m_valid));
            chk("init_done", 32'(init_done), 32'(m_done));
            eg = 2'b00;
            w  = pick_winner();
            if (ready && m_done && volume == m_vol_last && w >= 0)
                eg = (w == 0) ? 2'b01 : 2'b10;
            chk("gnt", 32'(gnt), 32'(eg));
            if (ready) begin
                m_valid = 1;
                if (!m_done) begin
                    m_cmd = init_word(m_frames);
                    if (m_frames == 1) m_vol_last = volume;
                    if (m_frames == 7) m_done = 1;
                end else if (volume != m_vol_last) begin
                    m_cmd      = vol_word(volume);
                    m_vol_last = volume;
                end else if (w >= 0) begin
                    m_cmd  = (w == 0) ? req0_cmd : req1_cmd;
                    m_pref = 1 - w;
                end else begin
                    m_cmd = 24'h80_0000;
                end
                m_frames++;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic frame(input logic [23:0] exp_cmd, input logic [1:0] exp_gnt, input string name);
        logic [1:0] g;
        ready = 1'b1;
        @(negedge clk);
        g = gnt;
        @(posedge clk);
        #1;
        ready = 1'b0;
        chk({name, "_gnt"}, 32'(g), 32'(exp_gnt));
        chk({name, "_cmd"}, 32'({command_address, command_data}), 32'(exp_cmd));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] init_tbl [8];
        init_tbl = '{24'h80_0000, 24'h04_0000, 24'h18_0808, 24'h1A_0000,
                     24'h1C_0F0F, 24'h0E_8048, 24'h0A_0000, 24'h20_8000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd", 32'({command_address, command_data}), 32'd0);
        chk("reset_done", 32'(init_done), 32'd0);
        reset_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_valid", 32'(command_valid), 32'd0);

        // Init table with volume=31, source=0; a request must not be granted.
        req = 2'b01;
        req0_cmd = 24'h18_0404;
        for (int i = 0; i < 8; i++) begin
            frame(init_tbl[i], 2'b00, "init");
            if (i == 6) chk("init_done_before_last", 32'(init_done), 32'd0);
        end
        chk("init_done_after_8", 32'(init_done), 32'd1);
        req = 2'b00;

        // Volume 31 -> 20, then filler
        volume = 5'd20;
        frame(24'h04_0B0B, 2'b00, "vol20");
        frame(24'h80_0000, 2'b00, "filler");

        // Both requesters held for four frames
        req = 2'b11;
        req0_cmd = 24'h18_0404;
        req1_cmd = 24'h1C_0000;
`ifdef AC97_ARB_ROUND_ROBIN_EN
        frame(24'h18_0404, 2'b01, "rr0");
        frame(24'h1C_0000, 2'b10, "rr1");
        frame(24'h18_0404, 2'b01, "rr2");
        frame(24'h1C_0000, 2'b10, "rr3");
`else
        frame(24'h18_0404, 2'b01, "fp0");
        frame(24'h18_0404, 2'b01, "fp1");
        frame(24'h18_0404, 2'b01, "fp2");
        frame(24'h18_0404, 2'b01, "fp3");
`endif

        // Volume change and req0 on the same frame: volume wins first
        req = 2'b01;
        volume = 5'd5;
        frame(24'h04_1A1A, 2'b00, "vol_first");
        frame(24'h18_0404, 2'b01, "req0_after_vol");
        req = 2'b00;
        frame(24'h80_0000, 2'b00, "filler2");

        // Reset mid-frame while a req1 command is being issued
        req = 2'b10;
        frame(24'h1C_0000, 2'b10, "req1_issue");
        @(negedge clk);
        #2;
        reset_b = 1'b0;
        #1;
        chk("midrst_cmd", 32'({command_address, command_data}), 32'd0);
        chk("midrst_valid", 32'(command_valid), 32'd0);
        chk("midrst_done", 32'(init_done), 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        frame(24'h80_0000, 2'b00, "restart0");
        frame(24'h04_1A1A, 2'b00, "restart1");
        req = 2'b00;

        // Randomized frames checked by the model
        for (int n = 0; n < 400; n++) begin
            req      = 2'($urandom_range(0, 3));
            req0_cmd = 24'($urandom);
            req1_cmd = 24'($urandom);
            if ($urandom_range(0, 3) == 0) volume = 5'($urandom);
            if ($urandom_range(0, 7) == 0) source = 3'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            ready = 1'b1;
            @(posedge clk);
            #1;
            ready = 1'b0;
            @(posedge clk);
            #1;
            if ($urandom_range(0, 49) == 0) begin
                @(negedge clk);
                #2;
                reset_b = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                reset_b = 1'b1;
            end
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
